int_div_32by16: RTL
===================

# int_div_32by16

Iterative integer divider for the extended execute path. It is the inverse of the 16x16 integer multiplier. It divides a 32-bit dividend by a 16-bit divisor, signed or unsigned, one quotient bit per cycle. It returns `{remainder, quotient}` on a 32-bit result bus with the same `ov`/`zr`/`neg` flag semantics as the extended ALU. The block sits beside the extended ALU and uses a start/done handshake, so the pipeline stalls on `busy`.

## Interface
Parameters:
- `ERR_PATTERN`, default 32'hDEADDEAD: value driven on `dst` for divide-by-zero or quotient overflow.

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  request a divide; accepted only when `busy`=0.
- `sgn`  input  1  1 = signed (DIV), 0 = unsigned (UDIV); captured at accept.
- `src0`  input  32  dividend; captured at accept.
- `src1`  input  32  divisor; only `src1[15:0]` is used; captured at accept.
- `busy`  output  1  a divide is in progress.
- `done`  output  1  one-cycle pulse; `dst` and flags are updated on the same edge.
- `dst`  output  32  `{remainder[15:0], quotient[15:0]}`, or `ERR_PATTERN`.
- `ov`  output  1  divide-by-zero or quotient not representable in 16 bits.
- `zr`  output  1  `dst` == 0.
- `neg`  output  1  signed mode: `quotient[15]`; unsigned mode: 0; 0 on error.

## Operation
- States: IDLE, LOAD, ITER, FIX, DONE.
- IDLE/DONE + `start`: the block latches operands and `sgn`, then goes to LOAD.
- IDLE/DONE without `start`: the block goes to or stays in IDLE.
- LOAD (1 cycle):
  - Form the magnitudes `|dividend|` (32-bit unsigned, so -2^31 → 0x80000000) and `|divisor|` (16-bit unsigned).
  - Record the quotient sign (`dvd[31]^dvs[15]`) and the remainder sign (`dvd[31]`). Both are zero in unsigned mode.
  - Set the error flag if `divisor` == 0.
  - Set the error flag if `|dividend|[31:16]` >= `|divisor|`, because the magnitude quotient would exceed 16 bits.
  - Load a 16-bit partial remainder with `|dividend|[31:16]` and the quotient shift register with `|dividend|[15:0]`.
- ITER (exactly 16 cycles, 4-bit counter):
  - Compute a 17-bit trial `{rem,q[15]} - {1'b0,|divisor|}` with restoring division.
  - If the trial is non-negative, keep the difference and shift in 1; otherwise shift in 0.
  - ITER runs even when the error flag is set, so latency is constant; its results are discarded.
- FIX (1 cycle):
  - Negate the quotient magnitude if its sign is set, and negate the remainder magnitude if its sign is set. Division truncates toward zero; the remainder takes the sign of the dividend.
  - In signed mode, set the error flag if the magnitude is > 0x7FFF with a positive sign, or > 0x8000 with a negative sign.
- DONE (1 cycle):
  - `done`=1, `busy`=0.
  - On error: `dst`=`ERR_PATTERN`, `ov`=1, `zr`=0, `neg`=0.
  - Otherwise: `dst`={rem,quot}, `ov`=0, `zr`=(`dst`==0), `neg`=`sgn`&`quot[15]`.
- `dst` and the flags hold their values until the next DONE.
- `start` while `busy`=1 is ignored; there is no queueing.

## Timing
- Reset (asynchronous assert, any state): IDLE; `busy`=0, `done`=0, `dst`=0, `ov`=0, `zr`=0, `neg`=0; all internal registers cleared.
- Reset mid-operation aborts the divide; no `done` is produced.
- `start` is sampled at edge E0. `busy`=1 after E0 through E17.
- Sequence: LOAD after E0, ITER after E1–E16, FIX after E17. `done`=1 and results update after E18.
- Latency is fixed at 18 cycles for every case, including errors.
- Back-to-back: `start` high during the DONE cycle is accepted. The next `done` comes 18 edges later; `busy` is 1 in the cycle after `done`.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Unsigned 100/7 (`src0`=0x64, `src1`=7, `sgn`=0) → `done` exactly 18 edges after the accept edge; `dst`=0x0002000E, `ov`=0, `zr`=0, `neg`=0.
- Signed -100/7 (`src0`=0xFFFFFF9C, `src1`=7, `sgn`=1) → `dst`=0xFFFEFFF2, `neg`=1, `ov`=0.
- Signed 100/-7 (`src1`=0x0000FFF9) → `dst`=0x0002FFF2, `neg`=1.
- Divide by zero (`src0`=0x1234, `src1`=0) → `dst`=0xDEADDEAD, `ov`=1, `zr`=0, `neg`=0, still 18-cycle latency.
- Overflow boundaries:
  - unsigned 0x00010000/1 → `ov`=1;
  - signed 0x00008000/1 → `ov`=1;
  - signed 0xFFFF8000/1 → `dst`=0x00008000, `neg`=1, `ov`=0;
  - unsigned 0x0000FFFF/1 → `dst`=0x0000FFFF, `ov`=0.
- Handshake and reset:
  - 0/5 → `dst`=0, `zr`=1;
  - `start` pulsed with new operands at cycle 5 of a busy divide → ignored, and the first result is unchanged;
  - back-to-back `start` in the DONE cycle → second `done` 18 edges later;
  - `rst_n` low during ITER → all outputs 0 immediately, no `done`; the next divide completes normally.

Source files
------------

// File: rtl/int_div_32by16.sv
// Purpose: iterative 32/16 restoring divider, signed or unsigned, returning {remainder, quotient} with ov/zr/neg flags.
// Latency: fixed 18 cycles from the accept edge to done, error cases included; one quotient bit per ITER cycle.
// Backpressure: start is taken only while busy=0 (IDLE or DONE); start during busy is dropped, nothing is queued.
module int_div_32by16 #(
  parameter logic [31:0] ERR_PATTERN = 32'hDEADDEAD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        sgn,
  input  logic [31:0] src0,
  input  logic [31:0] src1,
  output logic        busy,
  output logic        done,
  output logic [31:0] dst,
  output logic        ov,
  output logic        zr,
  output logic        neg
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ITER, S_FIX, S_DONE} state_t;

  state_t state_q, state_d;

  logic        sgn_q, sgn_d;
  logic [31:0] dvd_q, dvd_d;
  logic [15:0] dvs_q, dvs_d;     // raw divisor until LOAD, magnitude afterwards
  logic [15:0] rem_q, rem_d;     // partial remainder
  logic [15:0] quo_q, quo_d;     // quotient shift register (low dividend bits shift out of the top)
  logic [3:0]  cnt_q, cnt_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic        err_q, err_d;
  logic [31:0] dst_q, dst_d;
  logic        ov_q, ov_d;
  logic        zr_q, zr_d;
  logic        neg_q, neg_d;

  logic [31:0] dvd_abs;
  logic [15:0] dvs_abs;
  logic [16:0] trial;
  logic [15:0] quo_fix;
  logic [15:0] rem_fix;
  logic        fix_err;

  // Upper divisor half is architecturally ignored.
  logic        unused_src1_hi;
  assign unused_src1_hi = ^src1[31:16];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: a fixed walk LOAD -> 16x ITER -> FIX -> DONE, re-entered straight from DONE on start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: state_d = start ? S_LOAD : S_IDLE;
      S_LOAD:         state_d = S_ITER;
      S_ITER:         state_d = (cnt_q == 4'd15) ? S_FIX : S_ITER;
      S_FIX:          state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  // FSM outputs decoded from the registered state only, so no input reaches them combinationally.
  always_comb begin
    busy = (state_q == S_LOAD) || (state_q == S_ITER) || (state_q == S_FIX);
    done = (state_q == S_DONE);
  end

  assign dst = dst_q;
  assign ov  = ov_q;
  assign zr  = zr_q;
  assign neg = neg_q;

  // Datapath: operand capture, magnitude/sign setup, restoring iteration, sign fix-up and result latch.
  always_comb begin
    sgn_d  = sgn_q;
    dvd_d  = dvd_q;
    dvs_d  = dvs_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    cnt_d  = cnt_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    err_d  = err_q;
    dst_d  = dst_q;
    ov_d   = ov_q;
    zr_d   = zr_q;
    neg_d  = neg_q;

    dvd_abs = (sgn_q && dvd_q[31]) ? (~dvd_q + 32'd1) : dvd_q;
    dvs_abs = (sgn_q && dvs_q[15]) ? (~dvs_q + 16'd1) : dvs_q;
    trial   = {rem_q, quo_q[15]} - {1'b0, dvs_q};
    quo_fix = qneg_q ? (~quo_q + 16'd1) : quo_q;
    rem_fix = rneg_q ? (~rem_q + 16'd1) : rem_q;
    // Magnitude 0x8000 is only representable as a negative 16-bit quotient.
    fix_err = err_q || (sgn_q && ((!qneg_q && (quo_q > 16'h7FFF)) ||
                                  ( qneg_q && (quo_q > 16'h8000))));

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          sgn_d = sgn;
          dvd_d = src0;
          dvs_d = src1[15:0];
        end
      end
      S_LOAD: begin
        dvs_d  = dvs_abs;
        rem_d  = dvd_abs[31:16];
        quo_d  = dvd_abs[15:0];
        qneg_d = sgn_q && (dvd_q[31] ^ dvs_q[15]);
        rneg_d = sgn_q && dvd_q[31];
        // A high half >= divisor means the magnitude quotient needs more than 16 bits.
        err_d  = (dvs_q == 16'd0) || (dvd_abs[31:16] >= dvs_abs);
        cnt_d  = 4'd0;
      end
      S_ITER: begin
        cnt_d = cnt_q + 4'd1;
        if (!trial[16]) begin
          rem_d = trial[15:0];
          quo_d = {quo_q[14:0], 1'b1};
        end else begin
          rem_d = {rem_q[14:0], quo_q[15]};
          quo_d = {quo_q[14:0], 1'b0};
        end
      end
      S_FIX: begin
        if (fix_err) begin
          dst_d = ERR_PATTERN;
          ov_d  = 1'b1;
          zr_d  = 1'b0;
          neg_d = 1'b0;
        end else begin
          dst_d = {rem_fix, quo_fix};
          ov_d  = 1'b0;
          zr_d  = ({rem_fix, quo_fix} == 32'd0);
          neg_d = sgn_q && quo_fix[15];
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset clears everything so an aborted divide leaves no trace.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sgn_q  <= 1'b0;
      dvd_q  <= 32'd0;
      dvs_q  <= 16'd0;
      rem_q  <= 16'd0;
      quo_q  <= 16'd0;
      cnt_q  <= 4'd0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      err_q  <= 1'b0;
      dst_q  <= 32'd0;
      ov_q   <= 1'b0;
      zr_q   <= 1'b0;
      neg_q  <= 1'b0;
    end else begin
      sgn_q  <= sgn_d;
      dvd_q  <= dvd_d;
      dvs_q  <= dvs_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      cnt_q  <= cnt_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      err_q  <= err_d;
      dst_q  <= dst_d;
      ov_q   <= ov_d;
      zr_q   <= zr_d;
      neg_q  <= neg_d;
    end
  end

endmodule
